float_subtractor: RTL and testbench
===================================

Name: float_subtractor

Overview:
Multi-cycle IEEE-754 single-precision subtractor, z = x - y. It is the inverse-operation companion to float_adder in the ALU adder directory and uses the same operand/result/overflow conventions. It adds an explicit start/busy/done handshake so an ALU sequencer can issue operations back-to-back. It is a state-machine datapath: unpack, align, subtract, iterative normalise.

Parameters:
NORM_MAX, 24, maximum normalisation left-shift iterations before forced flush (bounds latency)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  request; x,y sampled on the cycle start=1 is accepted
x  input  32  minuend, IEEE-754 single
y  input  32  subtrahend, IEEE-754 single
z  output  32  result, valid from done pulse until next accepted start
overflow  output  2  00 ok, 01 overflow (result Inf), 10 underflow (flushed to zero), 11 invalid (NaN)
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse, z/overflow valid

Behaviour:
- Reset (rst=0, async): state=IDLE, z=0, overflow=00, busy=0, done=0, internal registers cleared. Reset mid-operation aborts with no done pulse.
- States (3-bit): IDLE 000, UNPACK 001, ALIGN 010, SUB 011, NORM 100, DONE 101.
- Start is accepted in IDLE or DONE only; ignored while busy. Operands are latched on acceptance.
- UNPACK: split sign/exp/mant. exp==0 operands are treated as signed zero (denormals flushed). Flip y sign.
  - Either operand NaN -> z=7FC00000, ov=11.
  - Inf - Inf with the same sign -> 7FC00000, ov=11.
  - Any other Inf -> signed Inf, ov=00.
  - All special cases go straight to DONE.
- ALIGN (1 cycle): swap so |a|>=|b|. Right-shift the smaller mantissa (hidden bit restored, 24 bits + 3 guard bits) by the exponent difference in one barrel shift. Differences >26 give zero.
- SUB (1 cycle): effective subtract if signs differ after the y flip, else add. Result sign is the sign of the larger magnitude. An exact zero result gives +0 and goes to DONE.
- NORM:
  - On carry out, shift right 1, exp+1 (single cycle).
  - Otherwise shift left 1 and decrement exp per cycle until bit23=1, at most NORM_MAX cycles.
  - Exponent >=255 -> signed Inf, ov=01.
  - Exponent <=0 -> signed zero, ov=10.
- Rounding: truncate (round toward zero); guard bits are discarded.
- DONE: done=1 for exactly one cycle and busy=0. z/overflow are held in DONE and IDLE until the next accepted start. DONE -> IDLE next cycle unless start=1, in which case -> UNPACK.
- Latency from accepted start to done: 4 + n cycles, where n = NORM iterations (>=1). Specials take 2 cycles. busy=1 from the cycle after acceptance through the cycle before done.
- Start high in the same cycle rst releases is ignored; the first edge after release only leaves reset.

Decomposition:
- Shared package float_pkg:
  - field widths (EXP_W=8, MAN_W=23, BIAS=127)
  - state encodings
  - overflow codes OV_NONE/OV_OVF/OV_UNF/OV_NAN
  - constants QNAN=7FC00000, PINF=7F800000, NINF=FF800000
- Sub-module fp32_unpack (combinational): field split, hidden bit, is_zero/is_inf/is_nan flags. Reusable by float_adder.

Test Plan:
- 40400000 - 3F800000 (3.0-1.0) -> z=40000000, ov=00, done 5 cycles after start, busy high in between.
- 3F800000 - C0000000 (1.0-(-2.0)) -> 40400000, ov=00. Then 3F800000 - 3F800000 -> 00000000, ov=00.
- 3F800000 - 3F800001 -> B4000000, ov=00, with 23 NORM cycles (latency 27); check that start pulses during busy are ignored.
- 7F7FFFFF - FF7FFFFF -> 7F800000, ov=01. Then 00800001 - 00800000 -> 00000000, ov=10.
- 7FC00000 - 3F800000 -> 7FC00000, ov=11. Then 7F800000 - 7F800000 -> 7FC00000, ov=11, 2-cycle latency.
- Drive rst=0 asynchronously mid-NORM -> z=0, ov=00, busy=0 immediately, no done pulse. A new start after release completes normally. Also check back-to-back start issued in DONE.

Source files
------------

// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision definitions for the float adder/subtractor family.
package float_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_UNPACK = 3'b001;
  localparam logic [2:0] S_ALIGN  = 3'b010;
  localparam logic [2:0] S_SUB    = 3'b011;
  localparam logic [2:0] S_NORM   = 3'b100;
  localparam logic [2:0] S_DONE   = 3'b101;

  localparam logic [1:0] OV_NONE = 2'b00;
  localparam logic [1:0] OV_OVF  = 2'b01;
  localparam logic [1:0] OV_UNF  = 2'b10;
  localparam logic [1:0] OV_NAN  = 2'b11;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;
  localparam logic [31:0] NINF = 32'hFF80_0000;

  // Operand split into fields; mant carries the restored hidden bit.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp32_fields_t;

  function automatic logic [31:0] signed_inf(input logic s);
    return s ? NINF : PINF;
  endfunction

endpackage

// File: rtl/fp32_unpack.sv
// Combinational field split of a single-precision value; denormals read as zero.
module fp32_unpack
  import float_pkg::*;
(
  input  logic [31:0]  i_v,
  output fp32_fields_t o_f
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_frac;
  logic             w_zero;

  assign w_exp  = i_v[30:23];
  assign w_frac = i_v[22:0];
  assign w_zero = (w_exp == '0);

  assign o_f.sign    = i_v[31];
  assign o_f.exp     = w_exp;
  assign o_f.mant    = w_zero ? '0 : {1'b1, w_frac};
  assign o_f.is_zero = w_zero;
  assign o_f.is_inf  = (w_exp == '1) && (w_frac == '0);
  assign o_f.is_nan  = (w_exp == '1) && (w_frac != '0);

endmodule

// File: rtl/float_subtractor.sv
// Multi-cycle single-precision subtractor z = x - y with start/busy/done handshake.
//
// state  | meaning
// IDLE   | waiting for start, last result held
// UNPACK | operands latched, specials resolved
// ALIGN  | larger magnitude selected, smaller right-shifted
// SUB    | effective add/subtract, exact zero detected
// NORM   | one normalise step per cycle
// DONE   | done pulse, result held, may accept a new start
module float_subtractor
  import float_pkg::*;
#(
  parameter int NORM_MAX = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] z,
  output logic [1:0]  overflow,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] L_NORM_MAX = 6'(NORM_MAX);

  logic [2:0]        r_state;
  logic              r_live;
  logic [31:0]       r_x, r_y, r_z;
  logic [1:0]        r_ov;
  logic              r_sign, r_sub;
  logic signed [9:0] r_exp;
  logic [26:0]       r_ma, r_mb;
  logic [27:0]       r_sum;
  logic [5:0]        r_cnt;

  fp32_fields_t w_fx, w_fy;
  logic         w_accept, w_special;
  logic [31:0]  w_spec_z;
  logic [1:0]   w_spec_ov;

  fp32_unpack u_unpack_x (.i_v(r_x), .o_f(w_fx));
  fp32_unpack u_unpack_y (.i_v(r_y), .o_f(w_fy));

  // The first edge after reset release only arms the block (r_live).
  assign w_accept  = start && r_live && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_special = w_fx.is_nan | w_fy.is_nan | w_fx.is_inf | w_fy.is_inf;

  // Special-operand result; y's sign is flipped since this is x + (-y).
  always_comb begin
    w_spec_z  = QNAN;
    w_spec_ov = OV_NAN;
    if (w_fx.is_nan || w_fy.is_nan) begin
      w_spec_z  = QNAN;
      w_spec_ov = OV_NAN;
    end else if (w_fx.is_inf && w_fy.is_inf) begin
      if (w_fx.sign != w_fy.sign) begin
        w_spec_z  = signed_inf(w_fx.sign);
        w_spec_ov = OV_NONE;
      end
    end else if (w_fx.is_inf) begin
      w_spec_z  = signed_inf(w_fx.sign);
      w_spec_ov = OV_NONE;
    end else begin
      w_spec_z  = signed_inf(~w_fy.sign);
      w_spec_ov = OV_NONE;
    end
  end

  logic        w_swap, w_lsign, w_eff_sub, w_small_zero;
  logic [7:0]  w_el, w_es, w_diff;
  logic [23:0] w_ml, w_ms;
  logic [26:0] w_ms_sh;

  assign w_swap       = {w_fy.exp, w_fy.mant} > {w_fx.exp, w_fx.mant};
  assign w_el         = w_swap ? w_fy.exp  : w_fx.exp;
  assign w_es         = w_swap ? w_fx.exp  : w_fy.exp;
  assign w_ml         = w_swap ? w_fy.mant : w_fx.mant;
  assign w_ms         = w_swap ? w_fx.mant : w_fy.mant;
  assign w_small_zero = w_swap ? w_fx.is_zero : w_fy.is_zero;
  assign w_lsign      = w_swap ? ~w_fy.sign : w_fx.sign;
  assign w_eff_sub    = (w_fx.sign == w_fy.sign);
  assign w_diff       = w_el - w_es;
  assign w_ms_sh      = (w_small_zero || (w_diff > 8'd26)) ? '0 : ({w_ms, 3'b000} >> w_diff);

  logic [27:0] w_sum;
  assign w_sum = r_sub ? ({1'b0, r_ma} - {1'b0, r_mb}) : ({1'b0, r_ma} + {1'b0, r_mb});

  logic [27:0]       w_nsum;
  logic signed [9:0] w_nexp;
  logic [5:0]        w_cnt_nx;
  logic              w_fin, w_flush;
  logic [31:0]       w_rz;
  logic [1:0]        w_rov;

  assign w_cnt_nx = r_cnt + 6'd1;

  // One normalise step; the hidden bit sits at bit 26 with 3 guard bits below.
  always_comb begin
    w_nsum  = r_sum;
    w_nexp  = r_exp;
    w_fin   = 1'b0;
    w_flush = 1'b0;
    if (r_sum[27]) begin
      w_nsum = r_sum >> 1;
      w_nexp = r_exp + 10'sd1;
      w_fin  = 1'b1;
    end else if (r_sum[26]) begin
      w_fin = 1'b1;
    end else begin
      w_nsum = r_sum << 1;
      w_nexp = r_exp - 10'sd1;
      if (w_nsum[26]) begin
        w_fin = 1'b1;
      end else if (w_cnt_nx >= L_NORM_MAX) begin
        w_flush = 1'b1;
      end
    end
  end

  // Pack the normalised value; guard bits are truncated away.
  always_comb begin
    w_rz  = {r_sign, w_nexp[7:0], w_nsum[25:3]};
    w_rov = OV_NONE;
    if (w_flush || (w_nexp <= 10'sd0)) begin
      w_rz  = {r_sign, 31'd0};
      w_rov = OV_UNF;
    end else if (w_nexp >= 10'sd255) begin
      w_rz  = signed_inf(r_sign);
      w_rov = OV_OVF;
    end
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_ov    <= OV_NONE;
      r_sign  <= 1'b0;
      r_sub   <= 1'b0;
      r_exp   <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_x <= x;
        r_y <= y;
      end
      case (r_state)
        S_IDLE: if (w_accept) r_state <= S_UNPACK;
        S_UNPACK: begin
          if (w_special) begin
            r_z     <= w_spec_z;
            r_ov    <= w_spec_ov;
            r_state <= S_DONE;
          end else begin
            r_state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_sign  <= w_lsign;
          r_sub   <= w_eff_sub;
          r_exp   <= {2'b00, w_el};
          r_ma    <= {w_ml, 3'b000};
          r_mb    <= w_ms_sh;
          r_state <= S_SUB;
        end
        S_SUB: begin
          if (w_sum == '0) begin
            r_z     <= '0;
            r_ov    <= OV_NONE;
            r_state <= S_DONE;
          end else begin
            r_sum   <= w_sum;
            r_cnt   <= '0;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (w_fin || w_flush) begin
            r_z     <= w_rz;
            r_ov    <= w_rov;
            r_state <= S_DONE;
          end else begin
            r_sum <= w_nsum;
            r_exp <= w_nexp;
            r_cnt <= w_cnt_nx;
          end
        end
        S_DONE:  r_state <= w_accept ? S_UNPACK : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign z        = r_z;
  assign overflow = r_ov;
  assign done     = (r_state == S_DONE);
  assign busy     = (r_state == S_UNPACK) || (r_state == S_ALIGN) ||
                    (r_state == S_SUB) || (r_state == S_NORM);

endmodule

// File: tb/tb_float_subtractor.sv
// Scoreboard bench for float_subtractor: directed cases plus randomized operands.
module tb_float_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x, y;
  logic [31:0] z;
  logic [1:0]  overflow;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] a, b, z;
    logic [1:0]  ov;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  float_subtractor #(.NORM_MAX(24)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .z(z), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Reference: exact aligned arithmetic on 24-bit significands with 3 guard bits,
  // truncating shift-out, normalised by leading-one position.
  function automatic void ref_sub(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rz, output logic [1:0] rov,
                                  output int rlat);
    int     ea, eb, el, es, d, p, e, n;
    logic   sa, sb, sl;
    bit     nan_a, nan_b, inf_a, inf_b;
    longint ma, mb, ml, ms, mbs, r, m, mag_a, mag_b;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sa = a[31];
    sb = ~b[31];
    nan_a = (ea == 255) && (a[22:0] != 0);
    nan_b = (eb == 255) && (b[22:0] != 0);
    inf_a = (ea == 255) && (a[22:0] == 0);
    inf_b = (eb == 255) && (b[22:0] == 0);
    rlat = 2;
    rov  = 2'b00;
    if (nan_a || nan_b) begin
      rz = 32'h7FC0_0000; rov = 2'b11;
    end else if (inf_a && inf_b) begin
      if (a[31] == b[31]) begin rz = 32'h7FC0_0000; rov = 2'b11; end
      else rz = sa ? 32'hFF80_0000 : 32'h7F80_0000;
    end else if (inf_a) begin
      rz = sa ? 32'hFF80_0000 : 32'h7F80_0000;
    end else if (inf_b) begin
      rz = sb ? 32'hFF80_0000 : 32'h7F80_0000;
    end else begin
      ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
      mb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(b[22:0]);
      mag_a = longint'(ea) * 16777216 + ma;
      mag_b = longint'(eb) * 16777216 + mb;
      if (mag_a >= mag_b) begin el = ea; ml = ma; sl = sa; es = eb; ms = mb; end
      else begin el = eb; ml = mb; sl = sb; es = ea; ms = ma; end
      d   = el - es;
      mbs = (d > 26) ? 0 : ((ms * 8) >> d);
      r   = (sa != sb) ? (ml * 8 - mbs) : (ml * 8 + mbs);
      if (r == 0) begin
        rz = 32'h0; rlat = 4;
      end else begin
        p = 0;
        for (int i = 0; i < 28; i++) if (r[i]) p = i;
        if (p == 27) begin m = r >> 1; e = el + 1; n = 1; end
        else if (p == 26) begin m = r; e = el; n = 1; end
        else begin n = 26 - p; m = r << n; e = el - n; end
        if (n > 24) begin
          rz = {sl, 31'd0}; rov = 2'b10; n = 24;
        end else if (e >= 255) begin
          rz = sl ? 32'hFF80_0000 : 32'h7F80_0000; rov = 2'b01;
        end else if (e <= 0) begin
          rz = {sl, 31'd0}; rov = 2'b10;
        end else begin
          rz = {sl, 8'(e), m[25:3]};
        end
        rlat = 4 + n;
      end
    end
  endfunction

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done with z=%h, expected no pulse", z);
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("z(%h-%h)", mon_e.a, mon_e.b), z, mon_e.z);
        chk($sformatf("ov(%h-%h)", mon_e.a, mon_e.b), 32'(overflow), 32'(mon_e.ov));
        chk($sformatf("latency(%h-%h)", mon_e.a, mon_e.b), 32'(cyc - mon_e.t0), 32'(mon_e.lat));
      end
    end
  end

  // Issue one operation at a negedge (now=1: already at one, e.g. in DONE) and wait for done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit now,
                        input bit noise, input bit use_exp, input logic [31:0] ez,
                        input logic [1:0] eov, input int elat);
    exp_t e;
    int   k, nbusy;
    if (!now) @(negedge clk);
    e.a = a;
    e.b = b;
    if (use_exp) begin e.z = ez; e.ov = eov; e.lat = elat; end
    else ref_sub(a, b, e.z, e.ov, e.lat);
    e.t0 = cyc;
    sb_q.push_back(e);
    start = 1'b1; x = a; y = b;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    k = 0;
    while (!done && k < 100) begin
      if (busy) nbusy++;
      if (noise && busy) begin
        start = k[0];
        x = $urandom;
        y = $urandom;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout(%h-%h): got no done in 100 cycles, expected done", a, b);
    end else begin
      chk($sformatf("busy_cycles(%h-%h)", a, b), 32'(nbusy), 32'(e.lat - 1));
    end
  endtask

  logic [31:0] specials [7] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
                                32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0001};

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b0; start = 1'b0; x = '0; y = '0;
    #3;
    chk("reset_z", z, 32'h0);
    chk("reset_ov", 32'(overflow), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_op(32'h4040_0000, 32'h3F80_0000, 0, 0, 1, 32'h4000_0000, 2'b00, 5);
    @(negedge clk);
    chk("z_hold_idle", z, 32'h4000_0000);
    chk("done_one_cycle", 32'(done), 32'h0);

    run_op(32'h3F80_0000, 32'hC000_0000, 0, 0, 1, 32'h4040_0000, 2'b00, 5);
    run_op(32'h3F80_0000, 32'h3F80_0000, 1, 0, 1, 32'h0000_0000, 2'b00, 4);
    run_op(32'h3F80_0000, 32'h3F80_0001, 0, 1, 1, 32'hB400_0000, 2'b00, 27);
    run_op(32'h7F7F_FFFF, 32'hFF7F_FFFF, 0, 0, 1, 32'h7F80_0000, 2'b01, 5);
    run_op(32'h0080_0001, 32'h0080_0000, 1, 0, 1, 32'h0000_0000, 2'b10, 27);
    run_op(32'h7FC0_0000, 32'h3F80_0000, 0, 0, 1, 32'h7FC0_0000, 2'b11, 2);
    run_op(32'h7F80_0000, 32'h7F80_0000, 1, 0, 1, 32'h7FC0_0000, 2'b11, 2);

    // Abort mid-normalise with an asynchronous reset.
    @(negedge clk);
    start = 1'b1; x = 32'h3F80_0000; y = 32'h3F80_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("abort_z", z, 32'h0);
    chk("abort_ov", 32'(overflow), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    repeat (3) @(negedge clk);
    chk("done_in_reset", 32'(done), 32'h0);
    start = 1'b1; x = 32'h4040_0000; y = 32'h3F80_0000;
    rst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_release_ignored", 32'(busy), 32'h0);
    run_op(32'h4040_0000, 32'h3F80_0000, 0, 0, 1, 32'h4000_0000, 2'b00, 5);
    run_op(32'h3F80_0000, 32'hC000_0000, 1, 0, 1, 32'h4040_0000, 2'b00, 5);

    for (int t = 0; t < 300; t++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: begin
          rb = ra;
          rb[30:23] = ra[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
          rb[22:0] = 23'($urandom);
          if ($urandom_range(0, 1) == 1) rb[31] = ~rb[31];
        end
        2: rb = ra ^ ($urandom & 32'h0000_00FF);
        3: begin
          rb = specials[$urandom_range(0, 6)];
          if ($urandom_range(0, 1) == 1) ra = specials[$urandom_range(0, 6)];
        end
        4: begin
          ra[30:23] = 8'd253 + 8'($urandom_range(0, 1));
          rb = ra;
          rb[31] = ~ra[31];
          rb[22:0] = 23'($urandom);
        end
        default: begin
          ra[30:23] = 8'($urandom_range(1, 3));
          rb = ra ^ ($urandom & 32'h007F_FFFF);
        end
      endcase
      run_op(ra, rb, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 0, '0, 2'b00, 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion by 2ms, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
